avalon_s_ram_device: RTL and testbench
======================================

# avalon_s_ram_device

Avalon-MM standard (non-pipelined) device-side responder backed by a single-port on-chip RAM with programmable wait states. Sits downstream of `avalon_s_arbiter` and is driven by its `device_avn_*` outputs. Completes every read and write by deasserting `avn_waitrequest` after a fixed number of stall cycles. Used as the default scratch/boot memory target and as the reference device for bus verification.

## Interface
Parameters:
- `DW`, 32: data width in bits; multiple of 8.
- `AW`, 32: byte address width.
- `DEPTH`, 1024: RAM depth in `DW`-bit words; power of two.
- `RD_WAIT`, 1: read wait states, i.e. cycles `avn_waitrequest` is high per read; legal range 1..15.
- `WR_WAIT`, 0: write wait states; legal range 0..15.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: reset; synchronous, active-low.
- `avn_read`  in  1: read request, held by the host until accepted.
- `avn_write`  in  1: write request, held by the host until accepted.
- `avn_address`  in  AW: byte address. Word index is `avn_address[log2(DW/8) +: log2(DEPTH)]`.
- `avn_byte_enable`  in  DW/8: per-byte write strobes; ignored on reads.
- `avn_writedata`  in  DW: write data.
- `avn_readdata`  out  DW: read data; valid in the read accept cycle.
- `avn_waitrequest`  out  1: stall; a request is accepted in the cycle it is high on the bus while this is low.

## Operation
- Wait counter `cnt`: width `$clog2(max(RD_WAIT,WR_WAIT)+1)`; reset value 0.
- States:
  - IDLE (`cnt==0`, no request).
  - WAIT (request present, `cnt < N`).
  - ACCEPT (request present, `cnt == N`).
  - N = `WR_WAIT` if `avn_write` is high; otherwise `RD_WAIT`.
- `avn_waitrequest` is combinational: high when `rst` is low; otherwise equals `(avn_write & cnt!=WR_WAIT) | (avn_read & !avn_write & cnt!=RD_WAIT)`. It is low when there is no request.
- WAIT cycle: `cnt <= cnt+1`.
- ACCEPT cycle, or a cycle with no request: `cnt <= 0`.
- Write accept: at the closing edge, bytes with `avn_byte_enable[b]=1` are written; other bytes are unchanged. No RAM update occurs in WAIT cycles.
- Read: every WAIT read cycle, `rdata_r <= mem[word]`. `avn_readdata = rdata_r`. `rdata_r` holds otherwise.
- Simultaneous read and write is a protocol violation. Write wins; the read is ignored and `rdata_r` holds.
- If the request drops mid-WAIT (protocol violation), `cnt` returns to 0, no memory effect, and `rdata_r` holds.
- Address, data and byte enables change mid-WAIT: the value sampled in the ACCEPT cycle (write) or in the last WAIT cycle (read) is used.
- Address bits above the word index are ignored; the RAM aliases.
- RAM contents are not reset.

## Timing
- Reset values: `avn_readdata`=0, `avn_waitrequest`=1 while `rst`=0, `cnt`=0.
- A reset asserted mid-transaction aborts it: no write occurs and the host sees waitrequest high.
- Read latency: `RD_WAIT+1` cycles from the request to the accept cycle. With `RD_WAIT`=1: read in cycle 0 gives waitrequest 1; cycle 1 gives waitrequest 0 and data valid.
- Write latency: `WR_WAIT+1` cycles. With `WR_WAIT`=0 the write is accepted in the request cycle.
- Back-to-back: a new request can be issued the cycle after accept and is timed from that cycle.
- Read-after-write to the same word returns the new data. The RAM update happens at the end of the write accept cycle, and a read needs at least 1 wait cycle.

## Configuration
- Macro `AVN_S_RAM_ADDR_CHECK_EN`.
- Defined: any nonzero address bit above `log2(DEPTH)+log2(DW/8)` marks the access out of range.
  - Out-of-range write: dropped.
  - Out-of-range read: `rdata_r` loads 0.
  - Handshake timing is identical to an in-range access.
- Undefined: upper bits are ignored and accesses alias into the RAM.

## Test plan
- Reset: hold `rst`=0 for 3 cycles with `avn_read`=1 -> `avn_waitrequest`=1 and `avn_readdata`=0 throughout; no RAM change.
- Write then read (`RD_WAIT`=1, `WR_WAIT`=0): write 0xDEADBEEF to 0x10, BE=0xF -> accepted in cycle 0. Read 0x10 next cycle -> waitrequest 1 then 0; data 0xDEADBEEF on the accept cycle.
- Byte enables: preload 0x11223344. Write 0xAABBCCDD with BE=0x5 -> readback 0x11BB33DD.
- Wait states (`RD_WAIT`=3, `WR_WAIT`=2): count waitrequest-high cycles -> exactly 3 per read and 2 per write. 10 back-to-back reads complete in 40 cycles.
- Violations: read and write together -> write performed, `rdata_r` unchanged. Request dropped after 1 WAIT cycle (`RD_WAIT`=3) -> next request again sees 3 wait cycles.
- Address check: with the macro, write 0x5 to `DEPTH*DW/8` -> word 0 unchanged and a read there returns 0. Without the macro, word 0 becomes 0x5.

Source files
------------

// File: rtl/avalon_s_ram_device.sv
// avalon_s_ram_device
//
// Avalon-MM device-side responder for the standard (non-pipelined) protocol.
// Sits behind avalon_s_arbiter and fronts a single-port on-chip RAM. Every read
// and write completes after a fixed number of stall cycles, set by RD_WAIT and
// WR_WAIT.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-low reset
//   avn_read         read request, held by the host until it is accepted
//   avn_write        write request, held by the host until it is accepted
//   avn_address      byte address; the word index is taken from the bits just
//                    above the byte-lane bits
//   avn_byte_enable  per-byte write strobes (ignored on reads)
//   avn_writedata    write data
//   avn_readdata     read data, valid in the read accept cycle
//   avn_waitrequest  stall; a request is accepted in a cycle where it is high
//                    while this output is low
//
// Optional feature:
//   AVN_S_RAM_ADDR_CHECK_EN - when defined, any nonzero address bit above the
//   word index marks the access out of range. Out-of-range writes are dropped
//   and out-of-range reads return zero. Handshake timing is unchanged. When
//   undefined, the upper bits are ignored and accesses alias into the RAM.
//
// RAM contents are never reset.

module avalon_s_ram_device #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int DEPTH   = 1024,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avn_read,
    input  logic              avn_write,
    input  logic [AW-1:0]     avn_address,
    input  logic [DW/8-1:0]   avn_byte_enable,
    input  logic [DW-1:0]     avn_writedata,
    output logic [DW-1:0]     avn_readdata,
    output logic              avn_waitrequest
);

    localparam int NB       = DW / 8;
    localparam int LG_BYTES = (NB > 1) ? $clog2(NB) : 0;
    localparam int LG_DEPTH = $clog2(DEPTH);
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT + 1);

    localparam logic [CW-1:0] RD_N = CW'(RD_WAIT);
    localparam logic [CW-1:0] WR_N = CW'(WR_WAIT);

    logic [CW-1:0]       cnt;
    logic [DW-1:0]       rdata_r;
    logic [DW-1:0]       mem [DEPTH];
    logic [LG_DEPTH-1:0] word;
    logic                is_write;
    logic                is_read;
    logic                wr_stall;
    logic                rd_stall;
    logic                in_range;
    logic                unused_addr;

    // A simultaneous read and write is treated as a write, so the read path
    // only sees requests where avn_write is low.
    assign word     = avn_address[LG_BYTES +: LG_DEPTH];
    assign is_write = avn_write;
    assign is_read  = avn_read & ~avn_write;

    // A request stalls until the counter reaches its wait-state count. The
    // cycle where the counter equals that count is the accept cycle.
    assign wr_stall = is_write & (cnt != WR_N);
    assign rd_stall = is_read  & (cnt != RD_N);

    // Reset forces a stall so a host caught mid-transaction never sees an
    // accept while the device is being cleared.
    assign avn_waitrequest = ~rst | wr_stall | rd_stall;

    assign avn_readdata = rdata_r;

`ifdef AVN_S_RAM_ADDR_CHECK_EN
    assign in_range = (avn_address >> (LG_BYTES + LG_DEPTH)) == '0;
`else
    assign in_range = 1'b1;
`endif

    // Byte-lane bits and, in the aliasing build, the upper address bits do
    // not select anything; fold them into a sink so the intent is explicit.
    assign unused_addr = ^avn_address;

    // Wait-state counter. It advances on every stalled request cycle and
    // returns to zero on accept, on an idle cycle, or when a host drops its
    // request part-way through the stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (wr_stall | rd_stall) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // RAM write port. Only the accept edge of a write updates memory, so data
    // and strobes that change during the stall have no effect until the host
    // settles them in the accept cycle. Gating on rst makes a reset abort any
    // write in progress.
    always_ff @(posedge clk) begin
        if (rst && is_write && !wr_stall && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (avn_byte_enable[b]) begin
                    mem[word][b*8 +: 8] <= avn_writedata[b*8 +: 8];
                end
            end
        end
    end

    // Read data register. It reloads on every stalled read cycle, so the
    // address held in the last stall cycle decides the data presented in the
    // accept cycle. Since a read always stalls for at least one cycle, a read
    // immediately after a write sees the freshly written word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (rd_stall) begin
            rdata_r <= in_range ? mem[word] : '0;
        end
    end

endmodule

// File: tb/tb_avalon_s_ram_device.sv
// Testbench for avalon_s_ram_device.
//
// Two instances are exercised: dut0 with the default wait states (read 1,
// write 0) and dut1 with read 3 / write 2. Each has its own bus signals and
// its own memory model, kept as an associative array of words.
// AVN_S_RAM_ADDR_CHECK_EN selects the expected out-of-range behaviour.

module tb_avalon_s_ram_device;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 1024;
    localparam int RD0   = 1;
    localparam int WR0   = 0;
    localparam int RD1   = 3;
    localparam int WR1   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          rd0 = 1'b0;
    logic          wr0 = 1'b0;
    logic [AW-1:0] addr0 = '0;
    logic [3:0]    be0 = '0;
    logic [DW-1:0] wd0 = '0;
    logic [DW-1:0] rdata0;
    logic          wait0;

    logic          rd1 = 1'b0;
    logic          wr1 = 1'b0;
    logic [AW-1:0] addr1 = '0;
    logic [3:0]    be1 = '0;
    logic [DW-1:0] wd1 = '0;
    logic [DW-1:0] rdata1;
    logic          wait1;

    int checks   = 0;
    int failures = 0;

    // Memory model for both devices, keyed by sel*DEPTH + word index.
    logic [31:0] model [int];

    always #5 clk = ~clk;

    avalon_s_ram_device #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_WAIT(RD0), .WR_WAIT(WR0)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .avn_read(rd0),
        .avn_write(wr0),
        .avn_address(addr0),
        .avn_byte_enable(be0),
        .avn_writedata(wd0),
        .avn_readdata(rdata0),
        .avn_waitrequest(wait0)
    );

    avalon_s_ram_device #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_WAIT(RD1), .WR_WAIT(WR1)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .avn_read(rd1),
        .avn_write(wr1),
        .avn_address(addr1),
        .avn_byte_enable(be1),
        .avn_writedata(wd1),
        .avn_readdata(rdata1),
        .avn_waitrequest(wait1)
    );

    // Reference model: plain arithmetic on the byte address.
    function automatic bit out_of_range(input logic [AW-1:0] a);
        return (a / (DEPTH * 4)) != 0;
    endfunction

    function automatic int word_of(input logic [AW-1:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic void model_write(input int sel, input logic [AW-1:0] a,
                                        input logic [31:0] d, input logic [3:0] b);
        int k;
        logic [31:0] cur;
        k = sel * DEPTH + word_of(a);
`ifdef AVN_S_RAM_ADDR_CHECK_EN
        if (out_of_range(a)) return;
`endif
        cur = model.exists(k) ? model[k] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) cur[i*8 +: 8] = d[i*8 +: 8];
        end
        model[k] = cur;
    endfunction

    function automatic void model_read(input int sel, input logic [AW-1:0] a,
                                       output bit known, output logic [31:0] v);
        int k;
        k = sel * DEPTH + word_of(a);
        known = 1'b0;
        v = '0;
`ifdef AVN_S_RAM_ADDR_CHECK_EN
        if (out_of_range(a)) begin
            known = 1'b1;
            return;
        end
`endif
        if (model.exists(k)) begin
            known = 1'b1;
            v = model[k];
        end
    endfunction

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
        if (sel == 0) begin
            rd0 = r; wr0 = w; addr0 = a; be0 = b; wd0 = d;
        end else begin
            rd1 = r; wr1 = w; addr1 = a; be1 = b; wd1 = d;
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Holds a request until accept (or a cycle budget runs out) and reports
    // the number of stalled cycles and the read data seen on accept.
    task automatic bus_op(input int sel, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d,
                          output logic [31:0] rdata, output int waits, output bit ok);
        logic wr_now;
        waits = 0;
        ok = 1'b0;
        rdata = '0;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            drive(sel, r, w, a, b, d);
            #1;
            wr_now = (sel == 0) ? wait0 : wait1;
            if (!wr_now) begin
                rdata = (sel == 0) ? rdata0 : rdata1;
                ok = 1'b1;
            end else begin
                waits++;
            end
        end
    endtask

    task automatic do_write(input int sel, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] b, input string tag);
        logic [31:0] rdv;
        int waits;
        int exp_w;
        bit ok;
        bus_op(sel, 1'b0, 1'b1, a, b, d, rdv, waits, ok);
        exp_w = (sel == 0) ? WR0 : WR1;
        checks++;
        if (!ok || waits !== exp_w) begin
            failures++;
            $display("[TB] FAIL %s write_waits dut%0d: got %0d (accepted=%0d) expected %0d",
                     tag, sel, waits, ok, exp_w);
        end
        if (ok) model_write(sel, a, d, b);
    endtask

    task automatic do_read(input int sel, input logic [AW-1:0] a, input string tag,
                           output logic [31:0] got, output int cycles);
        int waits;
        int exp_w;
        bit ok;
        bit known;
        logic [31:0] exp_d;
        bus_op(sel, 1'b1, 1'b0, a, '0, '0, got, waits, ok);
        cycles = waits + 1;
        exp_w = (sel == 0) ? RD0 : RD1;
        checks++;
        if (!ok || waits !== exp_w) begin
            failures++;
            $display("[TB] FAIL %s read_waits dut%0d: got %0d (accepted=%0d) expected %0d",
                     tag, sel, waits, ok, exp_w);
        end
        model_read(sel, a, known, exp_d);
        if (known) begin
            checks++;
            if (got !== exp_d) begin
                failures++;
                $display("[TB] FAIL %s read_data dut%0d addr=%h: got %h expected %h",
                         tag, sel, a, got, exp_d);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, '0, '0);
        drive(1, 1'b1, 1'b0, 32'h10, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (wait0 !== 1'b1 || wait1 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_wait cycle %0d: got %b/%b expected 1/1", c, wait0, wait1);
            end
            checks++;
            if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_rdata cycle %0d: got %h/%h expected 0/0", c, rdata0, rdata1);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_write_read();
        logic [31:0] got;
        int cyc;
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, "wr_rd");
        do_read(0, 32'h10, "wr_rd", got, cyc);
        checks++;
        if (got !== 32'hDEADBEEF) begin
            failures++;
            $display("[TB] FAIL wr_rd_const: got %h expected deadbeef", got);
        end
        idle(0);
    endtask

    task automatic test_byte_enable();
        logic [31:0] got;
        int cyc;
        do_write(0, 32'h20, 32'h11223344, 4'hF, "be");
        do_write(0, 32'h20, 32'hAABBCCDD, 4'h5, "be");
        do_read(0, 32'h20, "be", got, cyc);
        checks++;
        if (got !== 32'h11BB33DD) begin
            failures++;
            $display("[TB] FAIL be_const: got %h expected 11bb33dd", got);
        end
        idle(0);
    endtask

    task automatic test_wait_states();
        logic [31:0] got;
        int cyc;
        int total;
        for (int i = 0; i < 10; i++) begin
            do_write(1, 32'h200 + i * 4, $urandom, 4'hF, "ws_pre");
        end
        total = 0;
        for (int i = 0; i < 10; i++) begin
            do_read(1, 32'h200 + i * 4, "ws_b2b", got, cyc);
            total += cyc;
        end
        checks++;
        if (total !== 40) begin
            failures++;
            $display("[TB] FAIL b2b_cycles: got %0d expected 40", total);
        end
        idle(1);
    endtask

    task automatic test_violations();
        logic [31:0] got;
        logic [31:0] prev;
        logic [31:0] rdv;
        int waits;
        int cyc;
        bit ok;
        do_read(0, 32'h10, "viol", prev, cyc);
        bus_op(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, rdv, waits, ok);
        checks++;
        if (!ok || waits !== WR0) begin
            failures++;
            $display("[TB] FAIL rw_waits: got %0d (accepted=%0d) expected %0d", waits, ok, WR0);
        end
        if (ok) model_write(0, 32'h30, 32'hCAFEF00D, 4'hF);
        checks++;
        if (rdv !== prev) begin
            failures++;
            $display("[TB] FAIL rw_rdata_hold: got %h expected %h", rdv, prev);
        end
        idle(0);
        #1;
        checks++;
        if (rdata0 !== prev) begin
            failures++;
            $display("[TB] FAIL rw_rdata_hold_after: got %h expected %h", rdata0, prev);
        end
        do_read(0, 32'h30, "viol_rw", got, cyc);
        idle(0);

        do_write(1, 32'h40, 32'h0BADCAFE, 4'hF, "drop_pre");
        idle(1);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 32'h40, '0, '0);
        #1;
        checks++;
        if (wait1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL drop_read_stall: got %b expected 1", wait1);
        end
        idle(1);
        do_read(1, 32'h40, "drop_read", got, cyc);
        idle(1);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h55555555);
        idle(1);
        do_read(1, 32'h40, "drop_write", got, cyc);
        idle(1);
    endtask

    task automatic test_reset_abort();
        logic [31:0] got;
        int cyc;
        do_write(1, 32'h50, 32'h13579BDF, 4'hF, "abort_pre");
        idle(1);
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 32'h50, 4'hF, 32'hFFFF0000);
        #1;
        checks++;
        if (wait1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_stall: got %b expected 1", wait1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (wait1 !== 1'b1 || rdata1 !== 32'h0) begin
            failures++;
            $display("[TB] FAIL abort_reset: got wait=%b rdata=%h expected wait=1 rdata=0", wait1, rdata1);
        end
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        do_read(1, 32'h50, "abort_read", got, cyc);
        idle(1);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [AW-1:0] a;
        int cyc;
        for (int sel = 0; sel < 2; sel++) begin
            for (int i = 0; i < 8; i++) begin
                do_write(sel, 32'h100 + i * 4, $urandom, 4'hF, "rnd_pre");
            end
            for (int n = 0; n < 60; n++) begin
                a = 32'h100 + $urandom_range(0, 7) * 4 + $urandom_range(0, 3);
                if ($urandom_range(0, 1) == 1) begin
                    do_write(sel, a, $urandom, 4'($urandom_range(0, 15)), "rnd");
                end else begin
                    do_read(sel, a, "rnd", got, cyc);
                end
                if ($urandom_range(0, 3) == 0) idle(sel);
            end
            idle(sel);
        end
    endtask

    task automatic test_addr_check();
        logic [31:0] got0;
        logic [31:0] got_hi;
        int cyc;
        do_write(0, 32'h0, 32'h12345678, 4'hF, "ac_pre");
        do_write(0, DEPTH * 4, 32'h5, 4'hF, "ac_oor");
        do_read(0, 32'h0, "ac_word0", got0, cyc);
        do_read(0, DEPTH * 4, "ac_hi", got_hi, cyc);
        idle(0);
`ifdef AVN_S_RAM_ADDR_CHECK_EN
        checks++;
        if (got0 !== 32'h12345678 || got_hi !== 32'h0) begin
            failures++;
            $display("[TB] FAIL ac_const: got %h/%h expected 12345678/00000000", got0, got_hi);
        end
`else
        checks++;
        if (got0 !== 32'h5 || got_hi !== 32'h5) begin
            failures++;
            $display("[TB] FAIL ac_const: got %h/%h expected 00000005/00000005", got0, got_hi);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_wait_states();
        test_violations();
        test_reset_abort();
        test_random();
        test_addr_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
